// File: rtl/lut_bank_cfg_pkg.sv
// Shared definitions for the runtime-programmable LUT bank: table sizing and reset table.
package lut_pkg;

  localparam logic [15:0] INIT_DEFAULT = 16'hF896;

  // Total table bits: NCH channels of 2**K entries each.
  function automatic int unsigned tb(input int unsigned k, input int unsigned nch);
    return nch * (32'd1 << k);
  endfunction

endpackage

// File: rtl/lut_cfg_shift.sv
// Serial-load truth-table store: table shift register, load counter, valid/done flags.
module lut_cfg_shift
  import lut_pkg::*;
#(
  parameter int unsigned              K    = 3,
  parameter int unsigned              NCH  = 2,
  parameter logic [tb(K,NCH)-1:0]     INIT = INIT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_en,
  input  logic                          cfg_bit,
  input  logic                          cfg_clr,
  output logic [tb(K,NCH)-1:0]          o_table,
  output logic                          o_valid,
  output logic                          o_done,
  output logic [$clog2(tb(K,NCH))-1:0]  o_cnt
);

  localparam int unsigned TB = tb(K, NCH);
  localparam int unsigned CW = $clog2(TB);

  logic [TB-1:0] r_table;
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic          r_done;

  // rst and cfg_clr have identical effect here; only the output register tells them apart.
  always_ff @(posedge clk) begin
    if (rst || cfg_clr) begin
      r_table <= INIT;
      r_cnt   <= '0;
      r_valid <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (cfg_en) begin
        r_table <= {r_table[TB-2:0], cfg_bit};
        r_cnt   <= r_cnt + 1'b1;
        if (r_cnt == CW'(TB - 1)) begin
          r_valid <= 1'b1;
          r_done  <= 1'b1;
        end else if (r_cnt == '0) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign o_table = r_table;
  assign o_valid = r_valid;
  assign o_done  = r_done;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/lut_bank_cfg.sv
// Bank of NCH runtime-programmable K-input boolean functions with registered outputs.
module lut_bank_cfg
  import lut_pkg::*;
#(
  parameter int unsigned              K    = 3,
  parameter int unsigned              NCH  = 2,
  parameter logic [tb(K,NCH)-1:0]     INIT = INIT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [K-1:0]                  in,
  input  logic                          cfg_en,
  input  logic                          cfg_bit,
  input  logic                          cfg_clr,
  output logic [NCH-1:0]                lut_out,
  output logic                          cfg_valid,
  output logic                          cfg_done,
  output logic [$clog2(tb(K,NCH))-1:0]  cfg_cnt
);

  localparam int unsigned TB  = tb(K, NCH);
  localparam int unsigned ENT = 32'd1 << K;

  logic [TB-1:0]  w_table;
  logic [NCH-1:0] w_next;

  lut_cfg_shift #(
    .K    (K),
    .NCH  (NCH),
    .INIT (INIT)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .cfg_en  (cfg_en),
    .cfg_bit (cfg_bit),
    .cfg_clr (cfg_clr),
    .o_table (w_table),
    .o_valid (cfg_valid),
    .o_done  (cfg_done),
    .o_cnt   (cfg_cnt)
  );

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [ENT-1:0] w_row;
    assign w_row     = w_table[g*ENT +: ENT];
    assign w_next[g] = cfg_valid & w_row[in];
  end

  // cfg_clr deliberately leaves this register alone: it evaluates the pre-edge table.
  always_ff @(posedge clk) begin
    if (rst) lut_out <= '0;
    else     lut_out <= w_next;
  end

endmodule
